glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Glitch sequencer: after an armed trigger edge, waits delay_cfg cycles and
// emits num_cfg glitch pulses of width_cfg cycles separated by gap_cfg cycles.
//
// Ports:
//   clk       - single clock, all logic on rising edge
//   rst       - synchronous active-high reset
//   arm       - pulse; latches config and arms (from IDLE or DONE only)
//   abort     - pulse; returns to IDLE, glitch inactive, done untouched
//   trigger   - asynchronous trigger, synchronised internally
//   delay_cfg - cycles from trigger detection to first pulse
//   width_cfg - pulse width (0 treated as 1)
//   gap_cfg   - low cycles between pulses (0 treated as 1)
//   num_cfg   - pulses per trigger (0 treated as 1)
//   polarity  - 0 = active-high glitch, 1 = active-low glitch
//   glitch    - registered glitch output
//   armed     - high in ARMED
//   busy      - high in DELAY, PULSE or GAP
//   done      - sticky completion flag, cleared by arm or rst
module glitch_sequencer #(
   parameter int CNT_W       = 32,
   parameter int NUM_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             abort,
   input  logic             trigger,
   input  logic [CNT_W-1:0] delay_cfg,
   input  logic [CNT_W-1:0] width_cfg,
   input  logic [CNT_W-1:0] gap_cfg,
   input  logic [NUM_W-1:0] num_cfg,
   input  logic             polarity,
   output logic             glitch,
   output logic             armed,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_DELAY = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_W-1:0]       pcnt_q, pcnt_d;
   logic                   done_q, done_d;
   logic                   glitch_q, glitch_d;
   logic [CNT_W-1:0]       dly_q, wid_q, gap_q;
   logic [NUM_W-1:0]       num_q;
   logic                   pol_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   trig_prev_q;
   logic                   trig_rise;
   logic                   latch_en;
   logic                   dly_last, wid_last, gap_last, num_last;

   // Edge detector runs in every state so a level already high on
   // entering ARMED never looks like a fresh edge.
   assign trig_rise = sync_q[SYNC_STAGES-1] & ~trig_prev_q;

   // Zero-valued widths/gaps/counts behave as 1; comparing against
   // value-1 keeps the counters from ever needing to reach the value.
   assign dly_last = (cnt_q == dly_q - CNT_ONE);
   assign wid_last = (wid_q == '0) || (cnt_q == wid_q - CNT_ONE);
   assign gap_last = (gap_q == '0) || (cnt_q == gap_q - CNT_ONE);
   assign num_last = (num_q == '0) || (pcnt_q == num_q - NUM_ONE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      done_d   = done_q;
      latch_en = 1'b0;
      // Output lags the state by one cycle; this fixes the
      // trigger-to-glitch latency at delay + 3 with two sync flops.
      glitch_d = (state_q == S_PULSE) ? ~pol_q : pol_q;
      if (abort) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         pcnt_d   = '0;
         glitch_d = pol_q;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d  = S_ARMED;
                  latch_en = 1'b1;
                  done_d   = 1'b0;
                  cnt_d    = '0;
                  pcnt_d   = '0;
               end
            end
            S_ARMED: begin
               if (trig_rise) begin
                  state_d = (dly_q == '0) ? S_PULSE : S_DELAY;
                  cnt_d   = '0;
                  pcnt_d  = '0;
               end
            end
            S_DELAY: begin
               if (dly_last) begin
                  state_d = S_PULSE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_PULSE: begin
               if (wid_last) begin
                  cnt_d = '0;
                  if (num_last) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_GAP: begin
               if (gap_last) begin
                  state_d = S_PULSE;
                  cnt_d   = '0;
                  pcnt_d  = pcnt_q + NUM_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               pcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pcnt_q      <= '0;
         done_q      <= 1'b0;
         glitch_q    <= 1'b0;
         dly_q       <= '0;
         wid_q       <= '0;
         gap_q       <= '0;
         num_q       <= '0;
         pol_q       <= 1'b0;
         sync_q      <= '0;
         trig_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pcnt_q      <= pcnt_d;
         done_q      <= done_d;
         glitch_q    <= glitch_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger};
         trig_prev_q <= sync_q[SYNC_STAGES-1];
         if (latch_en) begin
            dly_q <= delay_cfg;
            wid_q <= width_cfg;
            gap_q <= gap_cfg;
            num_q <= num_cfg;
            pol_q <= polarity;
         end
      end
   end

   assign glitch = glitch_q;
   assign armed  = (state_q == S_ARMED);
   assign busy   = (state_q == S_DELAY) ||
                   (state_q == S_PULSE) ||
                   (state_q == S_GAP);
   assign done   = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: latency, pulse trains, polarity,
// level-vs-edge triggering, abort and reset.
module tb_glitch_sequencer;

   logic        clk = 1'b0;
   logic        rst, arm, abort, trigger, polarity;
   logic [31:0] delay_cfg, width_cfg, gap_cfg;
   logic [7:0]  num_cfg;
   logic        glitch, armed, busy, done;

   int checks = 0;
   int errors = 0;

   logic [31:0] cap, expv;

   glitch_sequencer dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort),
      .trigger(trigger), .delay_cfg(delay_cfg),
      .width_cfg(width_cfg), .gap_cfg(gap_cfg),
      .num_cfg(num_cfg), .polarity(polarity),
      .glitch(glitch), .armed(armed), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [31:0] d, input logic [31:0] w,
                      input logic [31:0] g, input logic [7:0] n,
                      input logic p);
      delay_cfg = d;
      width_cfg = w;
      gap_cfg   = g;
      num_cfg   = n;
      polarity  = p;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic trig_low();
      trigger = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
      polarity = 1'b0; delay_cfg = '0; width_cfg = '0;
      gap_cfg = '0; num_cfg = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_outs", {28'd0, glitch, armed, busy, done}, 32'h0);

      // single pulse: delay 10, width 4
      cfg(32'd10, 32'd4, 32'd0, 8'd1, 1'b0);
      chk("t1_armed", {31'd0, armed}, 32'd1);
      trigger = 1'b1;
      cap = '0;
      for (int i = 0; i < 26; i++) begin
         tick();
         cap[i] = glitch;
         if (i == 5) chk("t1_busy", {31'd0, busy}, 32'd1);
      end
      expv = 32'h0001_E000;
      chk("t1_wave", cap, expv);
      chk("t1_done", {30'd0, done, busy}, 32'd2);

      // pulse train: 11000110001100 from cycle 3
      trig_low();
      cfg(32'd0, 32'd2, 32'd3, 8'd3, 1'b0);
      chk("t2_doneclr", {31'd0, done}, 32'd0);
      trigger = 1'b1;
      cap = '0;
      for (int i = 0; i < 24; i++) begin
         tick();
         cap[i] = glitch;
         if (i == 12) chk("t2_notdone", {31'd0, done}, 32'd0);
      end
      expv = '0;
      expv[3] = 1'b1; expv[4] = 1'b1;
      expv[8] = 1'b1; expv[9] = 1'b1;
      expv[13] = 1'b1; expv[14] = 1'b1;
      chk("t2_wave", cap, expv);
      chk("t2_done", {31'd0, done}, 32'd1);

      // active-low, all-zero config: single 1-cycle low pulse
      trig_low();
      cfg(32'd0, 32'd0, 32'd0, 8'd0, 1'b1);
      tick();
      trigger = 1'b1;
      cap = '0;
      for (int i = 0; i < 16; i++) begin
         tick();
         cap[i] = glitch;
      end
      chk("t3_wave", cap, 32'h0000_FFF7);
      chk("t3_done", {31'd0, done}, 32'd1);

      // trigger held high across arm: no sequence
      cfg(32'd5, 32'd1, 32'd0, 8'd1, 1'b0);
      cap = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cap[i] = glitch;
      end
      chk("t4_level", cap, 32'h0);
      chk("t4_armed", {31'd0, armed}, 32'd1);
      trig_low();
      trigger = 1'b1;
      cap = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cap[i] = glitch;
         if (i == 2) trigger = 1'b0;
         if (i == 4) trigger = 1'b1;
      end
      chk("t4_wave", cap, 32'h0000_0100);
      chk("t4_done", {31'd0, done}, 32'd1);

      // abort from DONE keeps done
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abdone", {29'd0, armed, busy, done}, 32'd1);

      // abort mid-pulse
      trig_low();
      cfg(32'd0, 32'd8, 32'd0, 8'd1, 1'b0);
      trigger = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("t5_inpulse", {31'd0, glitch}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort", {28'd0, glitch, armed, busy, done}, 32'h0);

      // reset mid-pulse, active-low
      trig_low();
      cfg(32'd0, 32'd8, 32'd0, 8'd1, 1'b1);
      trigger = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("t6_inpulse", {31'd0, glitch}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst", {28'd0, glitch, armed, busy, done}, 32'h0);

      // abort beats arm
      trig_low();
      abort = 1'b1;
      arm = 1'b1;
      tick();
      abort = 1'b0;
      arm = 1'b0;
      chk("t7_abarm", {31'd0, armed}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
